// File: rtl/accum_pkg.sv
// Shared definitions for the visibility-accumulator scheduler: state encoding,
// default geometry and the index-width helper.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned PSUMS_DEFAULT = 8;
  localparam int unsigned CBITS_DEFAULT = 10;

  // A single partial sum still needs a 1-bit index port.
  function automatic int unsigned abits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_sched_wrapcount.sv
// Modulo counter: counts 0..last_i, flags the terminal value, and wraps to 0 on increment.
module wrapcount #(
  parameter int unsigned Width = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] value_o,
  output logic             wrap_o
);

  logic [Width-1:0] value_q, value_d;

  assign wrap_o  = (value_q == last_i);
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      value_d = wrap_o ? '0 : value_q + Width'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Visibility-accumulator scheduler: maps each sample strobe onto a time-multiplexed
// partial sum and issues registered first/last/index controls with frame-granular start/stop.
module accum_sched
  import accum_pkg::*;
#(
  parameter int unsigned PSUMS = PSUMS_DEFAULT,
  parameter int unsigned CBITS = CBITS_DEFAULT,
  parameter int unsigned ABITS = abits(PSUMS)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic [CBITS-1:0] count_i,
  input  logic             valid_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [ABITS-1:0] index_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             dropped_o
);

  state_e           state_q, state_d;
  logic [CBITS-1:0] cnt_max_q, cnt_max_d;
  logic [CBITS-1:0] count_min1, cnt_last;
  logic [ABITS-1:0] idx;
  logic [CBITS-1:0] cnt;
  logic             idx_wrap, cnt_wrap;
  logic             strobe, start, frame_done, at_origin;
  logic             dropped_q, dropped_d;

  assign cnt_last = cnt_max_q - CBITS'(1);

  wrapcount #(.Width(ABITS)) u_idx (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .inc_i      (strobe),
    .load_i     (start),
    .load_val_i ('0),
    .last_i     (ABITS'(PSUMS - 1)),
    .value_o    (idx),
    .wrap_o     (idx_wrap)
  );

  wrapcount #(.Width(CBITS)) u_cnt (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .inc_i      (strobe && idx_wrap),
    .load_i     (start),
    .load_val_i ('0),
    .last_i     (cnt_last),
    .value_o    (cnt),
    .wrap_o     (cnt_wrap)
  );

  always_comb begin
    strobe     = valid_i && (state_q != ST_IDLE);
    start      = (state_q == ST_IDLE) && enable_i;
    frame_done = strobe && idx_wrap && cnt_wrap;
    at_origin  = (idx == '0) && (cnt == '0);
    count_min1 = (count_i == '0) ? CBITS'(1) : count_i;
    cnt_max_d  = (start || frame_done) ? count_min1 : cnt_max_q;
    state_d    = state_q;
    dropped_d  = dropped_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d   = ST_RUN;
          dropped_d = 1'b0;
        end else if (valid_i) begin
          dropped_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Stop straight away only if the counters will sit at the frame origin.
        if (!enable_i) begin
          state_d = (frame_done || (at_origin && !strobe)) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end else if (frame_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      cnt_max_q <= CBITS'(1);
      dropped_q <= 1'b0;
      valid_o   <= 1'b0;
      first_o   <= 1'b0;
      last_o    <= 1'b0;
      frame_o   <= 1'b0;
      index_o   <= '0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_max_q <= cnt_max_d;
      dropped_q <= dropped_d;
      valid_o   <= strobe;
      first_o   <= strobe && (cnt == '0);
      last_o    <= strobe && cnt_wrap;
      frame_o   <= frame_done;
      if (strobe) begin
        index_o <= idx;
      end
      busy_o    <= (state_d != ST_IDLE);
    end
  end

  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched: vector table for gapless/count-0/gapped frames,
// plus hand sequences for drain, mid-frame count change and async reset.
module tb_accum_sched;

  logic       clock_i = 1'b0;
  logic       reset_ni;
  logic       enable_i;
  logic [9:0] count_i;
  logic       valid_i;
  logic       valid_o, first_o, last_o, frame_o, busy_o, dropped_o;
  logic [2:0] index_o;

  int checks = 0;
  int errors = 0;

  always #5 clock_i = ~clock_i;

  accum_sched dut (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .enable_i  (enable_i),
    .count_i   (count_i),
    .valid_i   (valid_i),
    .valid_o   (valid_o),
    .first_o   (first_o),
    .last_o    (last_o),
    .index_o   (index_o),
    .frame_o   (frame_o),
    .busy_o    (busy_o),
    .dropped_o (dropped_o)
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic [9:0] cnt;
    logic       ev;
    logic       ef;
    logic       el;
    logic       efr;
    logic [2:0] ei;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Strobe n (0-based) of a PSUMS*m frame.
  function automatic vec_t strobe_vec(input int n, input int m, input logic [9:0] c);
    vec_t v;
    v.en  = 1'b1;
    v.vld = 1'b1;
    v.cnt = c;
    v.ev  = 1'b1;
    v.ef  = (n < 8);
    v.el  = (n >= 8 * (m - 1));
    v.efr = (n == 8 * m - 1);
    v.ei  = 3'(n % 8);
    return v;
  endfunction

  function automatic vec_t gap_vec(input logic [9:0] c);
    vec_t v;
    v = '{en: 1'b1, vld: 1'b0, cnt: c, ev: 1'b0, ef: 1'b0, el: 1'b0, efr: 1'b0, ei: 3'd0};
    return v;
  endfunction

  // Each frame's final strobe presents the count that the next frame latches.
  task automatic frame_seq(input int m, input int change_at, input logic [9:0] new_count,
                           input int drop_at);
    for (int n = 0; n < 8 * m; n++) begin
      if (n == change_at) count_i = new_count;
      if (n == drop_at) enable_i = 1'b0;
      valid_i = 1'b1;
      tick();
      check("seq_valid", 32'(valid_o), 32'd1);
      check("seq_index", 32'(index_o), 32'(n % 8));
      check("seq_first", 32'(first_o), 32'(n < 8));
      check("seq_last", 32'(last_o), 32'(n >= 8 * (m - 1)));
      check("seq_frame", 32'(frame_o), 32'(n == 8 * m - 1));
      if (drop_at >= 0 && n >= drop_at && n < 8 * m - 1) check("drain_busy", 32'(busy_o), 32'd1);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0;
    enable_i = 1'b0;
    count_i  = 10'd3;
    valid_i  = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_first", 32'(first_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_frame", 32'(frame_o), 32'd0);
    check("rst_index", 32'(index_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_dropped", 32'(dropped_o), 32'd0);
    reset_ni = 1'b1;
    tick();

    // count 3 gapless, then count 0 (treated as 1), then count 2 gapped 1-on/2-off
    vecs.push_back(gap_vec(10'd3));
    for (int n = 0; n < 24; n++) vecs.push_back(strobe_vec(n, 3, (n == 23) ? 10'd0 : 10'd3));
    for (int n = 0; n < 8; n++) vecs.push_back(strobe_vec(n, 1, (n == 7) ? 10'd2 : 10'd0));
    for (int n = 0; n < 16; n++) begin
      vecs.push_back(strobe_vec(n, 2, 10'd2));
      vecs.push_back(gap_vec(10'd2));
      vecs.push_back(gap_vec(10'd2));
    end
    foreach (vecs[k]) begin
      enable_i = vecs[k].en;
      valid_i  = vecs[k].vld;
      count_i  = vecs[k].cnt;
      tick();
      check("tab_valid", 32'(valid_o), 32'(vecs[k].ev));
      check("tab_first", 32'(first_o), 32'(vecs[k].ef));
      check("tab_last", 32'(last_o), 32'(vecs[k].el));
      check("tab_frame", 32'(frame_o), 32'(vecs[k].efr));
      if (vecs[k].ev) check("tab_index", 32'(index_o), 32'(vecs[k].ei));
    end
    check("run_busy", 32'(busy_o), 32'd1);

    // Drop enable after strobe 10 of a count-2 frame
    frame_seq(2, -1, 10'd2, 10);
    tick();
    tick();
    check("drain_idle_busy", 32'(busy_o), 32'd0);
    check("drain_idle_valid", 32'(valid_o), 32'd0);
    valid_i = 1'b1;
    tick();
    check("idle_no_strobe", 32'(valid_o), 32'd0);
    valid_i = 1'b0;
    tick();
    check("dropped_set", 32'(dropped_o), 32'd1);

    // Count 2 -> 4 mid-frame: 16 strobes now, 32 in the next frame
    enable_i = 1'b1;
    count_i  = 10'd2;
    tick();
    check("restart_dropped", 32'(dropped_o), 32'd0);
    check("restart_busy", 32'(busy_o), 32'd1);
    frame_seq(2, 2, 10'd4, -1);
    frame_seq(4, -1, 10'd4, -1);

    // Async reset mid-frame, then re-enable
    count_i = 10'd2;
    for (int n = 0; n < 4; n++) begin
      valid_i = 1'b1;
      tick();
    end
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    check("pre_rst_index", 32'(index_o), 32'd3);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_valid", 32'(valid_o), 32'd0);
    check("async_index", 32'(index_o), 32'd0);
    check("async_busy", 32'(busy_o), 32'd0);
    valid_i = 1'b0;
    #3;
    reset_ni = 1'b1;
    tick();
    enable_i = 1'b1;
    tick();
    valid_i = 1'b1;
    tick();
    check("post_rst_valid", 32'(valid_o), 32'd1);
    check("post_rst_index", 32'(index_o), 32'd0);
    check("post_rst_first", 32'(first_o), 32'd1);
    check("post_rst_last", 32'(last_o), 32'd0);
    valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_sched.md
# accum_sched

Scheduler that sequences the visibility accumulator. It consumes the correlator front-end's sample strobe and assigns each strobe to one of PSUMS time-multiplexed partial sums. For each strobe it issues the registered valid/first/last/index controls that the accumulator and its partial-sum SRAM consume. It also marks frame boundaries for the downstream readout and supports clean start/stop at frame granularity.

## Interface
- PSUMS, 8, number of time-multiplexed partial sums (≥2, power of two)
- CBITS, 10, width of the per-accumulation sample count
- ABITS, derived $clog2(PSUMS), width of index_o

- clock_i  in  1  single system clock, all logic on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- enable_i  in  1  run request; level-sensitive
- count_i  in  CBITS  samples per partial sum per frame; 0 treated as 1
- valid_i  in  1  one correlator sample available this cycle
- valid_o  out  1  accumulator strobe
- first_o  out  1  first sample of this partial sum in the frame (accumulator loads, not adds)
- last_o  out  1  final sample of this partial sum in the frame (accumulator emits result)
- index_o  out  ABITS  partial-sum index for this strobe
- frame_o  out  1  one-cycle pulse coincident with last_o for index PSUMS-1
- busy_o  out  1  state ≠ IDLE
- dropped_o  out  1  sticky: valid_i seen while IDLE; cleared on IDLE→RUN

## Operation
- Registers: state, idx (ABITS), cnt (CBITS), cnt_max (CBITS, latched count, min 1).
- States: IDLE, RUN, DRAIN.
- IDLE:
  - valid_i is ignored for strobes and sets dropped_o.
  - enable_i=1 → RUN. The transition loads cnt_max=max(count_i,1), idx=0, cnt=0 and clears dropped_o.
- RUN / DRAIN, on each valid_i:
  - valid_o=1, index_o=idx, first_o=(cnt==0), last_o=(cnt==cnt_max-1).
  - idx increments. When idx==PSUMS-1 it wraps to 0 and cnt increments.
  - When cnt==cnt_max-1 and idx==PSUMS-1, the frame completes: frame_o=1, cnt→0, cnt_max reloads from count_i.
- RUN with enable_i=0 → DRAIN. DRAIN continues sequencing until the frame completes, then goes to IDLE. If idx==0 and cnt==0 (no frame in progress), RUN goes directly to IDLE.
- DRAIN with enable_i re-asserted → RUN. No frame is lost.
- count_i changes mid-frame have no effect until the next frame boundary.
- Cycles without valid_i produce valid_o=first_o=last_o=frame_o=0. idx and cnt hold.
- cnt_max==1: every strobe asserts first_o and last_o together.

## Timing
- All outputs are registered. valid_o, first_o, last_o, index_o and frame_o appear exactly 1 cycle after the qualifying valid_i edge.
- Throughput is one strobe per cycle with no gaps required.
- Reset values: state=IDLE, valid_o=0, first_o=0, last_o=0, frame_o=0, index_o=0, busy_o=0, dropped_o=0, idx=0, cnt=0, cnt_max=1.
- Reset mid-frame aborts the frame immediately, with no drain. The downstream accumulator treats the next first_o as a fresh load.
- enable_i and a frame-completing valid_i in the same cycle during DRAIN: the completing strobe is issued, and the state returns to RUN.
- busy_o is registered and tracks state one cycle after the transition edge.
- Frame length in strobes is PSUMS × cnt_max. The maximum is PSUMS × 2^CBITS−1 with no overflow, because cnt never exceeds cnt_max−1.

## Structure
- Shared package accum_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DRAIN
  - default PSUMS and CBITS
  - ABITS derivation helper
- One sub-module, wrapcount: a parameterised modulo counter with increment, load, wrap-flag output and async active-low reset. It is instantiated twice: for idx (modulus PSUMS) and for cnt (modulus cnt_max).
- No SRAM in this block. Index and controls drive the accumulator's partial-sum storage directly.

## Test plan
- Reset, enable_i=1, count_i=3, 24 consecutive valid_i:
  - index_o sequence 0..7 repeated 3×.
  - first_o on strobes 1–8, last_o on strobes 17–24.
  - frame_o only on strobe 24, one cycle after its valid_i.
- count_i=0, 8 strobes: every strobe has first_o=last_o=1, and frame_o on the 8th.
- Gapped valid_i (1 on / 2 off), count_i=2: identical control sequence to the gapless case, with valid_o=0 in gap cycles.
- Drop enable_i after strobe 10 of a count_i=2 frame:
  - busy_o stays 1 through strobe 16, frame_o fires on it, and busy_o=0 afterwards.
  - Further valid_i sets dropped_o.
- Change count_i 2→4 mid-frame: the current frame stays at 16 strobes, and the next frame is 32 strobes.
- Assert reset_ni=0 asynchronously at strobe 5, then release and re-enable: outputs clear immediately, and the next strobe shows index_o=0 with first_o=1.
